// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg
//   Shared types for the FIFO-fed UART transmitter.
//   tx_state_e    : transmitter FSM states (PARITY is used only when
//                   FIFO_UART_TX_PARITY_EN is defined).
//   TX_IDLE_LEVEL : level of the serial line when no frame is in flight.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
//   Free-running bit-period counter. It counts 0..CLKS_PER_BIT-1 and
//   pulses tick for one cycle on the last count, then wraps to 0.
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset (counter to 0)
//     clear : synchronous reload to 0; suppresses tick
//     tick  : one-cycle pulse at the end of each bit period
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains bytes from a synchronous FIFO read port and sends each one as
//   a UART frame: start bit, DATA_BITS data bits LSB first, optional even
//   parity bit, STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks.
//   Optional feature macro: FIFO_UART_TX_PARITY_EN (adds the parity bit).
//   Ports:
//     clk     : system clock, rising edge
//     rst_n   : asynchronous active-low reset; aborts any frame, tx=1
//     enable  : permits new frames to start
//     rempty  : FIFO empty flag, sampled only in IDLE
//     dataOut : FIFO read data, valid the cycle after re
//     re      : registered one-cycle FIFO read strobe (FETCH cycle)
//     tx      : registered serial output, idles high
//     busy    : high whenever the FSM is not in IDLE
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 rempty,
  input  logic [DATA_BITS-1:0] dataOut,
  output logic                 re,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned BW = $clog2(DATA_BITS) + 1;
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_e            state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic                 tick;
  logic                 baud_clear;
  logic                 tx_n;

`ifdef FIFO_UART_TX_PARITY_EN
  logic parity_q;

  // Parity is taken from the word as loaded; the shift register is
  // consumed during DATA and no longer holds the whole word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (state == LOAD) begin
      parity_q <= ^dataOut;
    end
  end
`endif

  // Bit timing runs only in the line-driving states, so every START entry
  // sees a freshly cleared counter; later boundaries wrap on tick.
  assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    case (state)
      IDLE: begin
        if (enable && !rempty) state_n = FETCH;
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        shift_n   = dataOut;
        bit_cnt_n = '0;
        state_n   = START;
      end
      START: begin
        if (tick) state_n = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_n = shift >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_n = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_n = '0;
            state_n   = IDLE;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // tx is registered from next-state values so the pad sees no glitches
  // and the line level lines up exactly with the state it belongs to.
  always_comb begin
    tx_n = TX_IDLE_LEVEL;
    case (state_n)
      START: tx_n = 1'b0;
      DATA:  tx_n = shift_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_n = parity_q;
`endif
      default: tx_n = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      re      <= 1'b0;
      tx      <= TX_IDLE_LEVEL;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      re      <= (state_n == FETCH);
      tx      <= tx_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Directed bench for fifo_uart_tx with CLKS_PER_BIT=4, DATA_BITS=8,
//   STOP_BITS=1, fed by a small behavioural FIFO (read data registered
//   one cycle after re). Define FIFO_UART_TX_PARITY_EN for the parity build.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NLEV = 11;
`else
  localparam int NLEV = 10;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       enable  = 1'b0;
  logic       rempty  = 1'b1;
  logic [7:0] dataOut = '0;
  logic       re, tx, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int re_count = 0;

  logic [7:0] fifo_q[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_BITS   (8),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .rempty (rempty),
    .dataOut(dataOut),
    .re     (re),
    .tx     (tx),
    .busy   (busy)
  );

  // FIFO read side: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (re && fifo_q.size() > 0) begin
      dataOut <= fifo_q[0];
      fifo_q.pop_front();
      rempty  <= (fifo_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (re) re_count++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    rempty <= 1'b0;
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef FIFO_UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Waits for the re pulse, then follows the whole frame cycle by cycle.
  // gap = idle-level cycles from call until the first start-bit cycle.
  task automatic run_frame(input logic [7:0] b, input string tag, input int drop_at,
                           output int gap, output logic [10:0] lev);
    int          k;
    int          errs;
    logic        got_re;
    logic [10:0] ef;
    errs   = 0;
    got_re = 1'b0;
    k      = 0;
    lev    = '1;
    ef     = exp_frame(b);
    while (!got_re && k < 200) begin
      @(negedge clk);
      k++;
      if (tx !== 1'b1) errs++;
      if (re === 1'b1) got_re = 1'b1;
    end
    gap = k + 1;
    check_eq({tag, "_re_seen"}, 32'(got_re), 32'd1);
    if (!got_re) return;
    @(negedge clk);
    if (tx !== 1'b1 || re !== 1'b0 || busy !== 1'b1) errs++;
    for (int i = 0; i < NLEV * CPB; i++) begin
      @(negedge clk);
      if (i == drop_at) enable = 1'b0;
      if (tx !== ef[i / CPB]) errs++;
      if (busy !== 1'b1 || re !== 1'b0) errs++;
      if (i % CPB == 2) lev[i / CPB] = tx;
    end
    check_eq({tag, "_shape"}, 32'(errs), 32'd0);
    check_eq({tag, "_data"}, 32'(lev[8:1]), 32'(b));
  endtask

  initial begin
    int          gap;
    int          base;
    int          viol;
    int          k;
    logic [10:0] lev;

    // Reset and idle
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_re", 32'(re), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    viol   = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || re !== 1'b0 || busy !== 1'b0) viol++;
    end
    check_eq("idle_empty_viol", 32'(viol), 32'd0);
    check_eq("idle_re_count", 32'(re_count), 32'd0);

    // Single byte 0xA5
    push(8'hA5);
    run_frame(8'hA5, "a5", -1, gap, lev);
`ifndef FIFO_UART_TX_PARITY_EN
    check_eq("a5_levels", 32'(lev[9:0]), 32'h34A);
`endif
    check_eq("a5_re_count", 32'(re_count), 32'd1);
    @(negedge clk);
    check_eq("a5_after_busy", 32'(busy), 32'd0);
    check_eq("a5_after_tx", 32'(tx), 32'd1);

    // Back-to-back 0x01, 0x80, 0xFF
    repeat (5) @(negedge clk);
    base = re_count;
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    run_frame(8'h01, "b2b0", -1, gap, lev);
    run_frame(8'h80, "b2b1", -1, gap, lev);
    check_eq("b2b1_gap", 32'(gap), 32'd3);
    run_frame(8'hFF, "b2b2", -1, gap, lev);
    check_eq("b2b2_gap", 32'(gap), 32'd3);
    repeat (20) @(negedge clk);
    check_eq("b2b_re_pulses", 32'(re_count - base), 32'd3);
    check_eq("b2b_rempty", 32'(rempty), 32'd1);
    check_eq("b2b_busy", 32'(busy), 32'd0);

    // enable dropped during DATA of frame 1
    base = re_count;
    push(8'h5A);
    push(8'h3C);
    run_frame(8'h5A, "en1", 20, gap, lev);
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) viol++;
    end
    check_eq("en_off_idle_viol", 32'(viol), 32'd0);
    check_eq("en_off_re_pulses", 32'(re_count - base), 32'd1);
    check_eq("en_off_rempty", 32'(rempty), 32'd0);
    enable = 1'b1;
    run_frame(8'h3C, "en2", -1, gap, lev);
    check_eq("en_on_re_pulses", 32'(re_count - base), 32'd2);

    // Reset in the middle of bit 3 of 0x55
    repeat (5) @(negedge clk);
    base = re_count;
    push(8'h55);
    push(8'h12);
    k = 0;
    while (re !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("mid_re_seen", 32'(re), 32'd1);
    @(negedge clk);
    repeat (18) @(negedge clk);
    check_eq("mid_pre_tx", 32'(tx), 32'd0);
    check_eq("mid_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", 32'(tx), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(8'h12, "post_rst", -1, gap, lev);
    check_eq("post_rst_re_pulses", 32'(re_count - base), 32'd2);

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity bit
    repeat (5) @(negedge clk);
    push(8'h07);
    run_frame(8'h07, "par07", -1, gap, lev);
    check_eq("par07_bit", 32'(lev[9]), 32'd1);
    push(8'h03);
    run_frame(8'h03, "par03", -1, gap, lev);
    check_eq("par03_bit", 32'(lev[9]), 32'd0);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
